jelly3_axi4l_register_slave: RTL and testbench
==============================================

// Module: jelly3_axi4l_register_slave
// PURPOSE
//  AXI4-Lite responder (slave end of jelly3_axi4l_if) that implements a bank of NUM_REGS
//  read/write control registers. Accepts AW and W independently, commits the write with
//  byte strobes, returns B and R responses and flags out-of-range accesses with SLVERR.
//  Drives the register contents to the fabric; it is the standard control endpoint behind an interconnect.
// PARAMETERS
//  ADDR_WIDTH  32                  AXI address width; must cover NUM_REGS*STRB_WIDTH bytes
//  DATA_WIDTH  32                  AXI data width (32 or 64)
//  STRB_WIDTH  DATA_WIDTH/8        write strobe width
//  NUM_REGS    8                   number of registers (>=1)
//  INIT_VALUE  '0                  [NUM_REGS-1:0][DATA_WIDTH-1:0] register reset values
// PORTS
//  aclk            in   1                    clock
//  aresetn         in   1                    asynchronous active-low reset
//  s_awaddr        in   ADDR_WIDTH           write address (awprot not used)
//  s_awvalid/ready in/out 1                  AW handshake
//  s_wdata         in   DATA_WIDTH           write data
//  s_wstrb         in   STRB_WIDTH           write byte enables
//  s_wvalid/ready  in/out 1                  W handshake
//  s_bresp         out  2                    00 OKAY, 10 SLVERR
//  s_bvalid/ready  out/in 1                  B handshake
//  s_araddr        in   ADDR_WIDTH           read address (arprot not used)
//  s_arvalid/ready in/out 1                  AR handshake
//  s_rdata         out  DATA_WIDTH           read data
//  s_rresp         out  2                    00 OKAY, 10 SLVERR
//  s_rvalid/ready  out/in 1                  R handshake
//  reg_q           out  NUM_REGS*DATA_WIDTH  register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//  reg_wstb        out  NUM_REGS             1-cycle pulse on the cycle after reg i was written
// BEHAVIOUR
//  Reset (async, aresetn=0): aw_hold=w_hold=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0,
//   reg_q=INIT_VALUE, reg_wstb=0; hence awready=wready=arready=1. In-flight transactions are dropped.
//  Decode: index = addr >> log2(STRB_WIDTH); low byte-offset bits ignored; in range iff index < NUM_REGS.
//  Write path:
//   - awready = ~aw_hold; wready = ~w_hold (combinational from flops).
//   - AW handshake latches awaddr and sets aw_hold. W handshake latches wdata/wstrb and sets w_hold.
//     The order is free (AW first, W first, or both in the same cycle).
//   - Commit occurs on the edge where aw_hold & w_hold & ~bvalid:
//     in range: each byte k with wstrb[k]=1 is updated; reg_wstb[index]=1 for one cycle; bresp=00.
//     out of range: no register change, no strobe, bresp=10.
//     On that edge bvalid<=1 and aw_hold, w_hold<=0.
//   - Latency: AW+W accepted at edge N -> bvalid high after edge N+1.
//   - bvalid is held, with bresp stable, until bvalid&bready. The next commit waits for that.
//     The next AW/W may be accepted (buffered) while B is pending.
//  Read path:
//   - arready = ~rvalid. On AR handshake, rdata = reg (or 0 if out of range), rresp = 00/10, rvalid<=1.
//   - Read latency is 1 cycle. rvalid, rdata and rresp are held stable until rvalid&rready.
//   - Back-to-back reads give 1 read per 2 cycles max; with rready tied high, 1 per 2 cycles.
//  Simultaneous read and commit to the same register on the same edge: read returns the old value.
//  Read and write paths are independent; neither blocks the other.
// TESTING
//  1 Reset: hold aresetn=0 with valids high -> bvalid=rvalid=0, reg_q=INIT_VALUE, no reg change after release.
//  2 AW addr 0x4 and W 0xDEADBEEF strb 0xF in the same cycle, bready=1
//    -> reg_q[63:32]=DEADBEEF, reg_wstb=0b10 one pulse, bresp=00 two cycles later.
//  3 W (0x11223344, strb 0x5) three cycles before AW (addr 0x4, prior value 0xDEADBEEF)
//    -> reg1=0xDE22BE44; wready low until commit.
//  4 Write then read addr 0x20 (NUM_REGS=8) -> bresp=10 and rresp=10, rdata=0, reg_q unchanged.
//  5 bready=0 for 5 cycles during 2 back-to-back writes
//    -> bvalid/bresp stable; 2nd AW/W latched; 2nd commit only after 1st B handshake; exactly 2 B beats.
//  6 rready toggling randomly with writes to the same reg
//    -> rdata stable while rvalid&~rready; same-edge conflict returns old value; async reset mid-transfer clears rvalid.

Source files
------------

// File: rtl/jelly3_axi4l_register_slave_if.sv
// AXI4-Lite bus bundle (no prot signals) shared between a master and
// a register-bank responder.
interface jelly3_axi4l_register_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/jelly3_axi4l_register_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed control registers with
// independent AW/W capture, SLVERR on out-of-range access, per-register write pulses.
module jelly3_axi4l_register_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0][DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  jelly3_axi4l_register_slave_if.slave   s_axi4l,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wstb
);
  localparam int        ADDR_SHIFT = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  aw_hold_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic                  w_hold_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_WIDTH-1:0] w_strb_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic                  rvalid_reg;
  logic [1:0]            rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic                  wstb_reg [NUM_REGS];

  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] aw_index;
  logic [ADDR_WIDTH-1:0] ar_index;
  logic                  aw_in_range;
  logic                  ar_in_range;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic [1:0]            rresp_next;
  logic [NUM_REGS-1:0]   reg_sel;

  assign s_axi4l.awready = ~aw_hold_reg;
  assign s_axi4l.wready  = ~w_hold_reg;
  assign s_axi4l.bvalid  = bvalid_reg;
  assign s_axi4l.bresp   = bresp_reg;
  assign s_axi4l.arready = ~rvalid_reg;
  assign s_axi4l.rvalid  = rvalid_reg;
  assign s_axi4l.rresp   = rresp_reg;
  assign s_axi4l.rdata   = rdata_reg;

  assign aw_fire = s_axi4l.awvalid & ~aw_hold_reg;
  assign w_fire  = s_axi4l.wvalid  & ~w_hold_reg;
  assign ar_fire = s_axi4l.arvalid & ~rvalid_reg;

  // A commit waits until the previous B beat has been taken.
  assign commit      = aw_hold_reg & w_hold_reg & ~bvalid_reg;
  assign aw_index    = aw_addr_reg >> ADDR_SHIFT;
  assign ar_index    = s_axi4l.araddr >> ADDR_SHIFT;
  assign aw_in_range = aw_index < ADDR_WIDTH'(NUM_REGS);
  assign ar_in_range = ar_index < ADDR_WIDTH'(NUM_REGS);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_hold_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_hold_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_hold_reg <= 1'b0;
      end else if (aw_fire) begin
        aw_hold_reg <= 1'b1;
        aw_addr_reg <= s_axi4l.awaddr;
      end
      if (commit) begin
        w_hold_reg <= 1'b0;
      end else if (w_fire) begin
        w_hold_reg <= 1'b1;
        w_data_reg <= s_axi4l.wdata;
        w_strb_reg <= s_axi4l.wstrb;
      end
      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi4l.bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign reg_sel[gi] = commit & aw_in_range & (aw_index == ADDR_WIDTH'(gi));
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
      assign reg_wstb[gi] = wstb_reg[gi];

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          regs_reg[gi] <= INIT_VALUE[gi];
          wstb_reg[gi] <= 1'b0;
        end else begin
          wstb_reg[gi] <= reg_sel[gi];
          if (reg_sel[gi]) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
              if (w_strb_reg[k]) begin
                regs_reg[gi][8*k +: 8] <= w_data_reg[8*k +: 8];
              end
            end
          end
        end
      end
    end
  endgenerate

  // Read mux sees pre-commit contents, so a same-edge read returns the old value.
  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_index == ADDR_WIDTH'(i)) begin
        rdata_next = regs_reg[i];
      end
    end
    rresp_next = ar_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_reg <= 1'b0;
      rresp_reg  <= RESP_OKAY;
      rdata_reg  <= '0;
    end else begin
      if (ar_fire) begin
        rvalid_reg <= 1'b1;
        rresp_reg  <= rresp_next;
        rdata_reg  <= rdata_next;
      end else if (s_axi4l.rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jelly3_axi4l_register_slave.sv
// Scoreboard bench for the AXI4-Lite register bank: directed corner cases
// followed by randomized traffic against an array model of the registers.
module tb_jelly3_axi4l_register_slave;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NR   = 8;
  localparam int MAXW = 60;
  localparam logic [NR-1:0][DW-1:0] INIT = {
    32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
    32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  jelly3_axi4l_register_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wstb;

  jelly3_axi4l_register_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .INIT_VALUE(INIT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axi4l(axi), .reg_q(reg_q), .reg_wstb(reg_wstb)
  );

  typedef struct { logic [1:0] resp; logic [NR*DW-1:0] regs; } b_exp_t;
  typedef struct { logic [1:0] resp; logic [DW-1:0] data; } r_exp_t;
  b_exp_t bq[$];
  r_exp_t rq[$];
  logic [DW-1:0] model [NR];

  int compared = 0;
  int mismatched = 0;
  int b_issued = 0, b_seen = 0, r_issued = 0, r_seen = 0;
  int bready_mode = 1, rready_mode = 1;

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = INIT[i];
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    b_exp_t e;
    logic [31:0] idx = addr >> 2;
    if (idx < NR) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
      e.resp = 2'b00;
    end else begin
      e.resp = 2'b10;
    end
    e.regs = model_flat();
    bq.push_back(e);
    b_issued++;
  endtask

  task automatic expect_read(input logic [31:0] addr);
    r_exp_t e;
    logic [31:0] idx = addr >> 2;
    e.resp = (idx < NR) ? 2'b00 : 2'b10;
    e.data = (idx < NR) ? model[idx] : 32'h0;
    rq.push_back(e);
    r_issued++;
  endtask

  task automatic send_aw(input logic [31:0] addr, input int dly);
    repeat (dly) begin @(posedge aclk); #1; end
    axi.awaddr = addr; axi.awvalid = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge aclk);
      if (axi.awready) break;
      if (c > MAXW) begin chk("aw_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    repeat (dly) begin @(posedge aclk); #1; end
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge aclk);
      if (axi.wready) break;
      if (c > MAXW) begin chk("w_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    axi.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input int dly);
    repeat (dly) begin @(posedge aclk); #1; end
    axi.araddr = addr; axi.arvalid = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge aclk);
      if (axi.arready) break;
      if (c > MAXW) begin chk("ar_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic wait_b();
    for (int c = 0; b_seen < b_issued; c++) begin
      if (c > MAXW) begin chk("b_timeout", b_seen, b_issued); break; end
      @(posedge aclk); #1;
    end
  endtask

  task automatic wait_r();
    for (int c = 0; r_seen < r_issued; c++) begin
      if (c > MAXW) begin chk("r_timeout", r_seen, r_issued); break; end
      @(posedge aclk); #1;
    end
  endtask

  // Ready generators: 0 = low, 1 = high, otherwise random per cycle.
  initial begin
    axi.bready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      axi.bready = (bready_mode == 0) ? 1'b0 : (bready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    axi.rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      axi.rready = (rready_mode == 0) ? 1'b0 : (rready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expectations on each B/R handshake and checks hold-stability.
  initial begin
    logic          b_stall = 1'b0, r_stall = 1'b0;
    logic [1:0]    b_prev_resp = '0, r_prev_resp = '0;
    logic [DW-1:0] r_prev_data = '0;
    b_exp_t be;
    r_exp_t re;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        b_stall = 1'b0; r_stall = 1'b0;
        continue;
      end
      if (b_stall) chk("b_hold", {axi.bvalid, axi.bresp}, {1'b1, b_prev_resp});
      if (r_stall) chk("r_hold", {axi.rvalid, axi.rresp, axi.rdata}, {1'b1, r_prev_resp, r_prev_data});
      if (axi.bvalid && axi.bready) begin
        b_seen++;
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = bq.pop_front();
          chk("bresp", axi.bresp, be.resp);
          chk("b_regs", reg_q, be.regs);
        end
      end
      if (axi.rvalid && axi.rready) begin
        r_seen++;
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          chk("rresp", axi.rresp, re.resp);
          chk("rdata", axi.rdata, re.data);
        end
      end
      b_stall = axi.bvalid && !axi.bready;
      b_prev_resp = axi.bresp;
      r_stall = axi.rvalid && !axi.rready;
      r_prev_resp = axi.rresp;
      r_prev_data = axi.rdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [31:0] addr, data;
    logic [3:0]  strb;
    model_reset();
    // Reset held with all valids asserted
    axi.awaddr = 32'h0; axi.awvalid = 1'b1;
    axi.wdata = '1; axi.wstrb = '1; axi.wvalid = 1'b1;
    axi.araddr = 32'h0; axi.arvalid = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
    chk("rst_readys", {axi.awready, axi.wready, axi.arready}, 3'b111);
    chk("rst_regs", reg_q, INIT);
    chk("rst_wstb", reg_wstb, 0);
    @(posedge aclk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    @(posedge aclk); #3;
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("post_rst_regs", reg_q, INIT);
    chk("post_rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
    @(posedge aclk); #1;

    // AW and W in the same cycle; strobe pulse and B latency
    expect_write(32'h4, 32'hDEADBEEF, 4'hF);
    axi.awaddr = 32'h4; axi.awvalid = 1'b1;
    axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge aclk);
    chk("t2_readys", {axi.awready, axi.wready}, 2'b11);
    @(posedge aclk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    @(negedge aclk);
    chk("t2_early", {axi.bvalid, reg_wstb}, 9'h0);
    @(negedge aclk);
    chk("t2_bvalid", {axi.bvalid, axi.bresp}, 3'b100);
    chk("t2_wstb", reg_wstb, 8'b0000_0010);
    chk("t2_reg1", reg_q[63:32], 32'hDEADBEEF);
    @(negedge aclk);
    chk("t2_wstb_end", reg_wstb, 0);
    @(posedge aclk); #1;
    wait_b();

    // W three cycles before AW, partial strobes
    expect_write(32'h4, 32'h11223344, 4'h5);
    send_w(32'h11223344, 4'h5, 0);
    repeat (3) begin
      @(negedge aclk);
      chk("t3_wready_low", axi.wready, 1'b0);
    end
    @(posedge aclk); #1;
    send_aw(32'h4, 0);
    wait_b();
    chk("t3_reg1", reg_q[63:32], 32'hDE22BE44);

    // Out-of-range write and read
    expect_write(32'h20, 32'h12345678, 4'hF);
    fork send_aw(32'h20, 0); send_w(32'h12345678, 4'hF, 1); join
    wait_b();
    expect_read(32'h20);
    send_ar(32'h20, 0);
    wait_r();

    // Two back-to-back writes while B is stalled
    bready_mode = 0;
    @(posedge aclk); #1;
    b0 = b_seen;
    expect_write(32'h8, 32'hCAFE0001, 4'hF);
    expect_write(32'hC, 32'hCAFE0002, 4'h3);
    fork send_aw(32'h8, 0); send_w(32'hCAFE0001, 4'hF, 0); join
    fork send_aw(32'hC, 0); send_w(32'hCAFE0002, 4'h3, 0); join
    repeat (5) begin
      @(negedge aclk);
      chk("t5_bvalid", {axi.bvalid, axi.bresp}, 3'b100);
    end
    chk("t5_second_latched", {axi.awready, axi.wready}, 2'b00);
    @(posedge aclk); #1;
    bready_mode = 1;
    wait_b();
    repeat (3) @(posedge aclk);
    #1;
    chk("t5_b_beats", b_seen - b0, 2);

    // Read and commit to the same register on the same edge
    expect_read(32'h10);
    expect_write(32'h10, 32'hFEEDF00D, 4'hF);
    fork send_aw(32'h10, 0); send_w(32'hFEEDF00D, 4'hF, 0); send_ar(32'h10, 1); join
    wait_b();
    wait_r();

    // Randomized traffic with random ready back-pressure
    bready_mode = 2;
    rready_mode = 2;
    for (int it = 0; it < 60; it++) begin
      addr = 32'($urandom_range(0, NR + 1)) * 4 + 32'($urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        expect_write(addr, data, strb);
        fork
          send_aw(addr, int'($urandom_range(0, 3)));
          send_w(data, strb, int'($urandom_range(0, 3)));
        join
        wait_b();
      end else begin
        expect_read(addr);
        send_ar(addr, int'($urandom_range(0, 2)));
        wait_r();
      end
    end

    // Asynchronous reset while a read response is stalled
    bready_mode = 1;
    rready_mode = 0;
    repeat (2) begin @(posedge aclk); #1; end
    expect_read(32'h0);
    send_ar(32'h0, 0);
    @(negedge aclk);
    chk("t6_rvalid_held", axi.rvalid, 1'b1);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_rvalid", {axi.rvalid, axi.bvalid, axi.arready}, 3'b001);
    chk("t6_rst_regs", reg_q, INIT);
    rq.delete();
    bq.delete();
    r_issued = r_seen;
    b_issued = b_seen;
    model_reset();
    @(posedge aclk); #3;
    aresetn = 1'b1;
    rready_mode = 1;
    @(posedge aclk); #1;
    expect_read(32'hC);
    send_ar(32'hC, 0);
    wait_r();

    repeat (2) @(posedge aclk);
    chk("final_queues", {32'(bq.size()), 32'(rq.size())}, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
